// File: rtl/mmio_uart_buffered_if.sv
// CPU-side MMIO bus of mmio_uart_buffered: MEM-stage address, store data,
// load/store strobes and the registered read data returned to the core.
interface mmio_uart_buffered_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/mmio_uart_buffered.sv
// MMIO window at 0x8000_xxxx: STATUS, RX/TX byte FIFOs, CYCLE/INSTRET counters.
// Optional RX interrupt and IRQ_EN register (0x0C) when MMIO_IRQ_EN is defined.
module mmio_uart_buffered #(
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_buffered_if.slave  bus,
    input  logic                 inst_retire,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 uart_rx_ready,
    output logic                 irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX      = 8'h04;
    localparam logic [7:0] OFF_TX      = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTRET = 8'h14;
    localparam logic [7:0] OFF_CNT_RST = 8'h18;
`ifdef MMIO_IRQ_EN
    localparam logic [7:0] OFF_IRQ     = 8'h0C;
`endif

    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TX_AW:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_count;
    logic [RX_AW:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_count;
    logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d, instret_q, instret_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        sel, rd_en, wr_en, stat_clr, cnt_rst;
    logic [7:0]  off;
    logic        tx_full, tx_empty, tx_pop, tx_push_req, tx_push;
    logic        rx_full, rx_empty, rx_pop, rx_push;
    logic [31:0] status, rd_val;

`ifdef MMIO_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
`endif

    // Address bits outside the decoded fields and the upper store-data bytes are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[27:8], bus.wdata[31:8]};

    always_comb begin
        sel      = (bus.addr[31:28] == 4'h8);
        off      = bus.addr[7:0];
        rd_en    = sel & bus.re;
        wr_en    = sel & bus.we;
        stat_clr = wr_en & (off == OFF_STATUS);
        cnt_rst  = wr_en & (off == OFF_CNT_RST);

        tx_count    = tx_wptr_q - tx_rptr_q;
        tx_empty    = (tx_wptr_q == tx_rptr_q);
        tx_full     = (tx_count == (TX_AW + 1)'(TX_DEPTH));
        tx_pop      = ~tx_empty & uart_tx_ready;
        tx_push_req = wr_en & (off == OFF_TX);
        // A full FIFO still accepts a store when the UART drains a slot in the same cycle.
        tx_push     = tx_push_req & (~tx_full | tx_pop);
        tx_wptr_d   = tx_wptr_q + (TX_AW + 1)'(tx_push);
        tx_rptr_d   = tx_rptr_q + (TX_AW + 1)'(tx_pop);
        tx_ovf_d    = (tx_ovf_q & ~stat_clr) | (tx_push_req & tx_full & ~tx_pop);

        rx_count  = rx_wptr_q - rx_rptr_q;
        rx_empty  = (rx_wptr_q == rx_rptr_q);
        rx_full   = (rx_count == (RX_AW + 1)'(RX_DEPTH));
        rx_pop    = rd_en & (off == OFF_RX) & ~rx_empty;
        rx_push   = uart_rx_valid & (~rx_full | rx_pop);
        rx_wptr_d = rx_wptr_q + (RX_AW + 1)'(rx_push);
        rx_rptr_d = rx_rptr_q + (RX_AW + 1)'(rx_pop);
        rx_ovf_d  = (rx_ovf_q & ~stat_clr) | (uart_rx_valid & rx_full & ~rx_pop);

        cycle_d   = cnt_rst ? '0 : cycle_q + CNT_WIDTH'(1);
        instret_d = cnt_rst ? '0 : instret_q + CNT_WIDTH'(inst_retire);

        status = {27'h0, tx_empty, tx_ovf_q, rx_ovf_q, ~rx_empty, ~tx_full};

        case (off)
            OFF_STATUS:  rd_val = status;
            OFF_RX:      rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr_q[RX_AW-1:0]]};
`ifdef MMIO_IRQ_EN
            OFF_IRQ:     rd_val = {31'h0, irq_en_q};
`endif
            OFF_CYCLE:   rd_val = 32'(cycle_q);
            OFF_INSTRET: rd_val = 32'(instret_q);
            default:     rd_val = 32'h0;
        endcase

        rdata_d = rdata_q;
        if (bus.re) begin
            rdata_d = sel ? rd_val : 32'h0;
        end

`ifdef MMIO_IRQ_EN
        irq_en_d = irq_en_q;
        if (wr_en && (off == OFF_IRQ)) begin
            irq_en_d = bus.wdata[0];
        end
        irq_d = irq_en_q & (~rx_empty | rx_ovf_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
            rdata_q   <= 32'h0;
`ifdef MMIO_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            rdata_q   <= rdata_d;
`ifdef MMIO_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.wdata[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wptr_q[RX_AW-1:0]] <= uart_rx_data;
        end
    end

    assign bus.rdata     = rdata_q;
    assign uart_tx_valid = ~tx_empty;
    assign uart_tx_data  = tx_mem[tx_rptr_q[TX_AW-1:0]];
    assign uart_rx_ready = 1'b1;

`ifdef MMIO_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_uart_buffered.sv
// Bench for mmio_uart_buffered: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the register map.
module tb_mmio_uart_buffered;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_retire;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_ready;
    logic       irq;

    always #5 clk = ~clk;

    mmio_uart_buffered_if bus ();

    mmio_uart_buffered #(.TX_DEPTH(D), .RX_DEPTH(D), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          m_rx_ovf, m_tx_ovf, m_irq_en, m_irq;
    logic [31:0] m_cyc, m_inst, m_rdata;

    function automatic void model_reset();
        rxq.delete();
        txq.delete();
        m_rx_ovf = 0; m_tx_ovf = 0; m_irq_en = 0; m_irq = 0;
        m_cyc = 0; m_inst = 0; m_rdata = 0;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[0] = (txq.size() < D);
        s[1] = (rxq.size() != 0);
        s[2] = m_rx_ovf;
        s[3] = m_tx_ovf;
        s[4] = (txq.size() == 0);
        return s;
    endfunction

    task automatic idle();
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.we = 1'b0; bus.re = 1'b0;
        inst_retire = 1'b0; uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
    endtask

    // One clock: predict from pre-edge model state, advance the model, check at negedge.
    task automatic tick();
        logic [31:0] a, wd;
        logic [7:0]  off, rxd;
        logic        sel, rd, wr, txr, rxv, ret, irq_nx, tx_pop, rx_pop;
        a = bus.addr; wd = bus.wdata; off = a[7:0];
        sel = (a[31:28] == 4'h8);
        rd = bus.re; wr = sel && bus.we;
        txr = uart_tx_ready; rxv = uart_rx_valid; rxd = uart_rx_data; ret = inst_retire;
        if (rd) begin
            if (!sel) m_rdata = 32'h0;
            else begin
                case (off)
                    8'h00: m_rdata = model_status();
                    8'h04: m_rdata = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
`ifdef MMIO_IRQ_EN
                    8'h0C: m_rdata = {31'h0, m_irq_en};
`endif
                    8'h10: m_rdata = m_cyc;
                    8'h14: m_rdata = m_inst;
                    default: m_rdata = 32'h0;
                endcase
            end
        end
        irq_nx = m_irq_en && ((rxq.size() != 0) || m_rx_ovf);
        tx_pop = (txq.size() != 0) && txr;
        rx_pop = rd && sel && (off == 8'h04) && (rxq.size() != 0);
        @(posedge clk);
        if (tx_pop) void'(txq.pop_front());
        if (rx_pop) void'(rxq.pop_front());
        if (wr && off == 8'h00) begin m_rx_ovf = 0; m_tx_ovf = 0; end
        if (wr && off == 8'h08) begin
            if (txq.size() < D) txq.push_back(wd[7:0]); else m_tx_ovf = 1;
        end
        if (rxv) begin
            if (rxq.size() < D) rxq.push_back(rxd); else m_rx_ovf = 1;
        end
`ifdef MMIO_IRQ_EN
        if (wr && off == 8'h0C) m_irq_en = wd[0];
`endif
        if (wr && off == 8'h18) begin m_cyc = 0; m_inst = 0; end
        else begin m_cyc = m_cyc + 1; m_inst = m_inst + 32'(ret); end
        m_irq = irq_nx;
        @(negedge clk);
        check("rdata", bus.rdata, m_rdata);
        check("tx_valid", 32'(uart_tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check("tx_data", 32'(uart_tx_data), 32'(txq[0]));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus_rd(input logic [7:0] off, output logic [31:0] v);
        bus.addr = 32'h8000_0000 | 32'(off); bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        v = bus.rdata;
        $display("rd  0x%02h -> 0x%08h", off, v);
    endtask

    task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
        bus.addr = 32'h8000_0000 | 32'(off); bus.wdata = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
        $display("wr  0x%02h <- 0x%08h", off, d);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [31:0] v;
    logic [7:0]  drained[D];
    logic [7:0]  offs[8];
    int          need;

    initial begin
        idle();
        rst = 1'b1;
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

        // Reset state
        do_reset();
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rx_ready", 32'(uart_rx_ready), 32'h1);
        bus_rd(8'h00, v);
        check("status_rst", v, 32'h0000_0011);

        // TX ordering with a stalled then pulsed UART
        bus_wr(8'h08, 32'hA5);
        bus_wr(8'h08, 32'h3C);
        check("tx_head_a5", 32'(uart_tx_data), 32'hA5);
        uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
        check("tx_head_3c", 32'(uart_tx_data), 32'h3C);
        uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
        check("tx_drained", 32'(uart_tx_valid), 32'h0);
        bus_rd(8'h00, v);
        check("tx_empty_bit", 32'(v[4]), 32'h1);

        // RX overflow: nine bytes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'(i); tick();
        end
        uart_rx_valid = 1'b0;
        bus_rd(8'h00, v);
        check("status_rx_ovf", v, 32'h0000_0017);
        for (int i = 1; i <= 8; i++) begin
            bus_rd(8'h04, v);
            check("rx_byte", v, 32'(i));
        end
        bus_rd(8'h04, v);
        check("rx_empty_read", v, 32'h0);
        bus_wr(8'h00, 32'h0);
        bus_rd(8'h00, v);
        check("rx_ovf_clr", 32'(v[2]), 32'h0);

        // TX full: push with simultaneous pop, then a dropped push
        for (int i = 0; i < D; i++) bus_wr(8'h08, 32'h10 + 32'(i));
        uart_tx_ready = 1'b1;
        bus_wr(8'h08, 32'h99);
        uart_tx_ready = 1'b0;
        bus_rd(8'h00, v);
        check("tx_full_no_ovf", 32'(v[3]), 32'h0);
        check("tx_full_bit0", 32'(v[0]), 32'h0);
        bus_wr(8'h08, 32'hEE);
        bus_rd(8'h00, v);
        check("tx_ovf_set", 32'(v[3]), 32'h1);
        for (int i = 0; i < D; i++) begin
            drained[i] = uart_tx_data;
            uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
        end
        check("tx_first_left", 32'(drained[0]), 32'h11);
        check("tx_new_last", 32'(drained[D-1]), 32'h99);
        check("tx_after_drain", 32'(uart_tx_valid), 32'h0);
        bus_wr(8'h00, 32'hFFFF_FFFF);

        // Counters
        bus_wr(8'h18, 32'h0);
        need = 40;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(99 - i, 0) < need) begin inst_retire = 1'b1; need--; end
            else inst_retire = 1'b0;
            tick();
        end
        inst_retire = 1'b0;
        bus_rd(8'h14, v);
        check("instret_40", v, 32'd40);
        bus_rd(8'h10, v);
        check("cycle_ge_100", 32'(v >= 32'd100), 32'h1);
        bus_wr(8'h18, 32'h1234);
        bus_rd(8'h14, v);
        check("instret_rst", v, 32'h0);
        bus_rd(8'h10, v);
        check("cycle_small", 32'(v < 32'd4), 32'h1);

        // CYCLE wrap from all-ones
        tick();
        force dut.cycle_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        bus_rd(8'h10, v);
        check("cycle_all_ones", v, 32'hFFFF_FFFF);
        bus_rd(8'h10, v);
        check("cycle_wrap", v, 32'h0);

        // RX interrupt
`ifdef MMIO_IRQ_EN
        bus_wr(8'h0C, 32'h1);
        bus_rd(8'h0C, v);
        check("irq_en_rd", v, 32'h1);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; tick(); uart_rx_valid = 1'b0;
        check("irq_not_yet", 32'(irq), 32'h0);
        tick();
        check("irq_set", 32'(irq), 32'h1);
        bus_rd(8'h04, v);
        check("irq_pop_data", v, 32'h5A);
        tick();
        check("irq_clr", 32'(irq), 32'h0);
`else
        bus_wr(8'h0C, 32'h1);
        bus_rd(8'h0C, v);
        check("irq_en_absent", v, 32'h0);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; tick(); uart_rx_valid = 1'b0;
        tick();
        check("irq_tied", 32'(irq), 32'h0);
        bus_rd(8'h04, v);
        check("rx_pop_5a", v, 32'h5A);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.addr      = (($urandom_range(9, 0) == 0) ? 32'h1000_0000 : 32'h8000_0000)
                            | 32'(offs[$urandom_range(7, 0)]);
            bus.re        = ($urandom_range(2, 0) == 0);
            bus.we        = ($urandom_range(3, 0) == 0);
            bus.wdata     = $urandom;
            uart_rx_valid = ($urandom_range(3, 0) == 0);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(2, 0) == 0);
            inst_retire   = ($urandom_range(1, 0) == 0);
            tick();
        end
        idle();

        // Reset while bytes are buffered
        bus_wr(8'h08, 32'h77);
        bus_wr(8'h08, 32'h78);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h42; tick(); uart_rx_valid = 1'b0;
        do_reset();
        check("rst2_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst2_rdata", bus.rdata, 32'h0);
        bus_rd(8'h00, v);
        check("rst2_status", v, 32'h0000_0011);
        bus_rd(8'h04, v);
        check("rst2_rx_empty", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_buffered.md
Name: mmio_uart_buffered

Overview:
- Memory-mapped I/O block for the RV151 core: status, RX/TX byte FIFOs, cycle counter and retired-instruction counter, all decoded at the 0x8000_xxxx window.
- Replaces the unbuffered single-byte UART status/data path.
- Sits between the core's MEM stage (address, store data, load strobe) and the on-chip UART's ready/valid ports.
- Adds parametrised TX/RX buffering, sticky overflow flags and software counter reset.

Parameters:
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥2)
- CNT_WIDTH, 32, width of cycle and instruction counters (≤32, zero-extended on read)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  32  MEM-stage byte address (ALU result)
- wdata  in  32  store data; only [7:0] used for TX
- we  in  1  store strobe, valid this cycle
- re  in  1  load strobe, valid this cycle
- inst_retire  in  1  one instruction retired this cycle (non-bubble WB)
- rdata  out  32  read data, registered
- uart_tx_data  out  8  head of TX FIFO to UART data_in
- uart_tx_valid  out  1  to UART data_in_valid
- uart_tx_ready  in  1  from UART data_in_ready
- uart_rx_data  in  8  from UART data_out
- uart_rx_valid  in  1  from UART data_out_valid
- uart_rx_ready  out  1  to UART data_out_ready
- irq  out  1  RX interrupt (see Optional Feature)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Select: sel = (addr[31:28] == 4'h8). Register by addr[7:0]:
  - 0x00 STATUS RO: bit0 TX not full, bit1 RX not empty, bit2 RX overflow, bit3 TX overflow, bit4 TX empty, others 0. A write of any value clears bits 2–3.
  - 0x04 RX DATA RO: {24'b0, head}; a read pops.
  - 0x08 TX DATA WO: pushes wdata[7:0].
  - 0x10 CYCLE RO.
  - 0x14 INSTRET RO.
  - 0x18 CNT_RST WO: any write zeroes both counters.
- Unmapped offsets: reads return 0, writes are ignored. When sel=0: no side effects and rdata=0.
- Read latency: 1 cycle.
  - rdata is registered at the edge following re; it holds its value when re=0.
  - STATUS reads sample pre-edge state.
  - An RX DATA read when empty returns 0 and leaves pointers unchanged.
- RX FIFO:
  - uart_rx_ready is tied 1.
  - A byte is pushed when uart_rx_valid=1.
  - If full and not popped the same cycle: byte dropped, RX overflow set (sticky).
  - Simultaneous push and pop when full: both occur, no overflow.
  - Pointers are log2(depth)+1 bits and wrap; count = wptr − rptr.
- TX FIFO:
  - uart_tx_valid = not empty; uart_tx_data = head, combinational from storage.
  - Pop on uart_tx_valid & uart_tx_ready.
  - Push when full without a same-cycle pop: byte dropped, TX overflow set. Push and pop in the same cycle when full: both occur.
- Counters:
  - CYCLE increments every cycle, wrapping at 2^CNT_WIDTH.
  - INSTRET increments on inst_retire.
  - A CNT_RST write takes priority: both counters read 0 on the next cycle and resume counting after that.
- Simultaneous CPU read and UART push/pop: fully independent, no lost events.
- Reset: FIFOs empty, flags 0, counters 0, rdata=0, uart_tx_valid=0, irq=0. Reset mid-transfer discards all buffered bytes; the UART is reset by the same rst.

Optional Feature:
- MMIO_IRQ_EN defined:
  - Register 0x0C IRQ_EN, RW, bit0. Reset value 0.
  - irq is registered: irq = IRQ_EN[0] & (RX not empty | RX overflow), asserted 1 cycle after the condition.
- MMIO_IRQ_EN undefined:
  - irq is tied 0.
  - 0x0C reads 0 and writes are ignored.

Test Plan:
- After reset, read 0x8000_0000 → rdata = 0x0000_0011 (TX not full, TX empty); uart_tx_valid = 0.
- Write 0xA5, 0x3C to 0x8000_0008 with uart_tx_ready=0 → uart_tx_valid=1, uart_tx_data=0xA5. Raise ready for 1 cycle → data=0x3C. Raise for 1 more cycle → valid=0, STATUS bit4=1.
- Push 9 RX bytes 0x01..0x09 (RX_DEPTH=8), no reads:
  - STATUS = 0x0000_0017.
  - Eight 0x8000_0004 reads return 0x01..0x08.
  - A ninth read returns 0.
  - Write 0x8000_0000 → bit2 clears.
- TX FIFO full, then write and UART pop in the same cycle → no TX overflow, 8 entries remain; the new byte appears last.
- Run 100 cycles with inst_retire high on 40 of them → CYCLE ≥ 100, INSTRET = 40. Write 0x8000_0018 → next reads are small and INSTRET restarts at 0. Preload CYCLE to all-ones (force) → wraps to 0.
- With MMIO_IRQ_EN:
  - Write 1 to 0x8000_000C, push RX byte → irq=1 the next cycle.
  - Pop it → irq=0 one cycle later.
  - With the macro undefined, irq stays 0 throughout.
